// File: rtl/dtc_sched_pkg.sv
// Shared widths and payload types for the decision-tree classifier scheduler.
package dtc_sched_pkg;

  localparam int unsigned FEAT_W = 12;
  localparam int unsigned CLS_W  = 3;
  localparam int unsigned NCLASS = 8;

  typedef logic [FEAT_W-1:0] feat_t;
  typedef logic [CLS_W-1:0]  cls_t;

endpackage

// File: rtl/dtc_rr_arb.sv
// Combinational round-robin arbiter: first active request at or above ptr, wrapping.
module dtc_rr_arb #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any_grant
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [NREQ-1:0]  rot;
  logic [SUM_W-1:0] sum;

  // Rotate so bit 0 is the pointer position, then pick the lowest set bit.
  always_comb begin
    rot       = NREQ'({req, req} >> ptr);
    sum       = '0;
    any_grant = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (en && !any_grant && rot[k]) begin
        any_grant = 1'b1;
        sum       = {1'b0, ptr} + SUM_W'(k);
      end
    end
    if (sum >= SUM_W'(NREQ)) sum = sum - SUM_W'(NREQ);
    grant_idx = sum[IDX_W-1:0];
    grant     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant[i] = any_grant && (grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/dtc_sched.sv
// Shares one classifier among NREQ requesters: RR arbitration, two-stage pipe, valid/ready result.
// Optional per-class result histogram enabled with `define DTC_SCHED_HIST_EN.
module dtc_sched
  import dtc_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*FEAT_W-1:0] req_feat,
  output logic [NREQ-1:0]        req_ready,
  output logic [FEAT_W-1:0]      cls_feat,
  input  logic [CLS_W-1:0]       cls_class,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLS_W-1:0]       out_class,
  output logic [ID_W-1:0]        out_id,
  input  logic [2:0]             hist_sel,
  input  logic                   hist_clr,
  output logic [CNT_W-1:0]       hist_cnt
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic             a_valid;
  feat_t            feat_q;
  logic [ID_W-1:0]  a_id;
  logic [IDX_W-1:0] rr_ptr;

  logic             b_free;
  logic             a_adv;
  logic             a_free;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any_grant;
  feat_t            grant_feat;

  assign b_free = !out_valid || out_ready;
  assign a_adv  = a_valid && b_free;
  // Held in reset so no requester sees an accept while the pipe is cleared.
  assign a_free = (!a_valid || a_adv) && rst_n;

  dtc_rr_arb #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .en        (a_free),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = grant;
  assign cls_feat  = feat_q;

  always_comb begin
    grant_feat = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_feat = grant_feat | req_feat[i*FEAT_W +: FEAT_W];
    end
  end

  // Stage A: granted features feed the external classifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      feat_q  <= '0;
      a_id    <= '0;
      rr_ptr  <= '0;
    end else if (any_grant) begin
      a_valid <= 1'b1;
      feat_q  <= grant_feat;
      a_id    <= ID_W'(grant_idx);
      rr_ptr  <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end

  // Stage B: capture the classifier result alongside the requester id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_class <= '0;
      out_id    <= '0;
    end else if (a_adv) begin
      out_valid <= 1'b1;
      out_class <= cls_class;
      out_id    <= a_id;
    end else if (b_free) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DTC_SCHED_HIST_EN
  logic [CNT_W-1:0] bins [NCLASS];
  logic [CNT_W-1:0] hist_q;

  // Saturating per-class counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCLASS; i++) bins[i] <= '0;
      hist_q <= '0;
    end else begin
      if (hist_clr) begin
        for (int unsigned i = 0; i < NCLASS; i++) bins[i] <= '0;
      end else if (out_valid && out_ready && (bins[out_class] != '1)) begin
        bins[out_class] <= bins[out_class] + 1'b1;
      end
      hist_q <= bins[hist_sel];
    end
  end

  assign hist_cnt = hist_q;
`else
  logic unused_hist;
  assign unused_hist = ^{hist_sel, hist_clr};
  assign hist_cnt    = '0;
`endif

endmodule

// File: doc/dtc_sched.md
# dtc_sched

Shares one combinational decision-tree classifier among NREQ requesters. Round-robin arbitration picks one request per cycle and registers its 12-bit feature vector onto the classifier input. The 3-bit class result is captured one cycle later and returned with the requester ID over a valid/ready output port with backpressure. The block sits between feature producers and the classifier instance, which lives outside this block and connects through the cls_* ports.

## Interface
- NREQ, 4: number of requesters, 2..8
- ID_W, 2: requester ID width, at least $clog2(NREQ)
- CNT_W, 16: histogram counter width (used only with DTC_SCHED_HIST_EN)
- clk  in  1: clock, rising edge
- rst_n  in  1: reset, asynchronous, active-low
- req_valid  in  NREQ: per-requester request valid
- req_feat  in  NREQ*12: per-requester feature vectors; requester i uses [12*i +: 12]
- req_ready  out  NREQ: one-hot (or zero) accept
- cls_feat  out  12: registered features driven to the classifier
- cls_class  in  3: combinational classifier result
- out_valid  out  1: result valid
- out_ready  in  1: consumer ready
- out_class  out  3: class result
- out_id  out  ID_W: index of the requester that issued the request
- hist_sel  in  3: histogram bin select
- hist_clr  in  1: synchronous clear of all bins
- hist_cnt  out  CNT_W: count for bin hist_sel

## Operation
- Two stages:
  - Stage A register: a_valid, feat_q (driven onto cls_feat), a_id.
  - Stage B register: out_valid, out_class, out_id.
- b_free = !out_valid | out_ready.
- a_adv = a_valid & b_free. When a_adv is high, the clock edge loads out_class <= cls_class and out_id <= a_id, and sets out_valid.
- If a_valid is low and b_free is high, out_valid clears on the edge.
- a_free = !a_valid | a_adv.
- Arbitration:
  - If a_free is high, the first requester i with req_valid[i] is granted, searching from rr_ptr upward modulo NREQ.
  - req_ready[i] = grant[i]. req_ready is combinational from req_valid, out_ready and state.
  - On a grant: feat_q <= req_feat[i], a_id <= i, a_valid <= 1, rr_ptr <= (i+1) mod NREQ.
  - With no grant and a_adv high: a_valid <= 0.
  - rr_ptr changes only on a grant.
- feat_q and a_id hold while a_valid is high and a_adv is low.
- Requests hold their feature vector while waiting. The block itself does not require req_valid to stay asserted.
- Reset mid-operation clears both stages. In-flight requests are dropped with no output.

## Timing
- Reset values: req_ready 0, cls_feat 0, out_valid 0, out_class 0, out_id 0, rr_ptr 0, hist_cnt 0.
- Latency: a request accepted at edge N raises out_valid after edge N+1.
- Throughput: one result per cycle while out_ready stays high.
- Full pipeline with out_ready low: both stages hold, req_ready is all-zero, and out_* stays stable.
- out_ready rising while both stages are full: the result leaves, stage A advances, and a new grant is issued in the same cycle.
- out_valid, once asserted, does not drop until the handshake completes.

## Configuration
- DTC_SCHED_HIST_EN defined:
  - NCLASS=8 saturating counters, CNT_W bits each.
  - Bin out_class increments on every output handshake (out_valid & out_ready).
  - A counter saturates at all-ones.
  - hist_clr zeroes all bins and takes priority over a same-cycle increment.
  - hist_cnt = bin[hist_sel], registered (1-cycle read latency).
- DTC_SCHED_HIST_EN undefined: no counters; hist_cnt is tied to 0; hist_sel and hist_clr are ignored.

## Structure
- Package dtc_sched_pkg: FEAT_W=12, CLS_W=3, NCLASS=8, typedef feat_t, typedef cls_t.
- Sub-module dtc_rr_arb:
  - Parameter NREQ.
  - Inputs: req, en, ptr.
  - Outputs: one-hot grant, encoded grant index, any_grant.
  - Purely combinational; the pointer register stays in dtc_sched.

## Test plan
For all scenarios the bench classifier model returns cls_class = cls_feat[2:0].
- Reset with req_valid=4'b1111 held: all outputs 0 during reset. First edge after release grants req0; out_id sequence is 0,1,2,3,0 with out_ready=1.
- Single requester 2, feat=12'h005, idle pipe: req_ready[2]=1 at edge N; out_valid=1, out_class=3'b101, out_id=2 after edge N+1.
- out_ready=0 with 3 requests pending: exactly 2 accepts, then req_ready=0 and out_* stable for 10 cycles. Raising out_ready drains results in grant order, one per cycle.
- req_valid=4'b1010 from reset: grants alternate 1,3,1,3. rr_ptr skips idle requesters.
- Histogram (macro on): 5 results with class 3 → hist_sel=3 reads 5. hist_clr asserted on the same cycle as a class-3 handshake → 0.
- Async reset asserted mid-stream with out_valid=1: out_valid drops immediately. No stale result appears after release.
